bin_to_bcd_seq: RTL

Sequential, parametrised binary-to-BCD converter for the clock display path. It converts CH binary channels, such as hours, minutes and seconds, into DIGITS packed BCD digits each. One shared shift-and-add-3 (double-dabble) engine handles the channels in turn, replacing per-channel divide/modulo logic. The block sits between the timekeeping counters and the seven-segment digit drivers, with a start/busy/done handshake and registered, double-buffered outputs.

---
 rtl/bin_to_bcd_seq.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential multi-channel binary-to-BCD converter (shared double-dabble engine)
//
// Converts CH unsigned WIDTH-bit channels into DIGITS packed BCD digits each,
// one channel at a time, through a single shift-and-add-3 engine.
//
// Parameters:
//   WIDTH  (>= 4)  binary width of each channel
//   DIGITS (>= 1)  BCD digits produced per channel
//   CH             number of channels
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   start    in   conversion request, sampled only when idle
//   bin_in   in   CH*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   busy     out  high while a conversion is in flight (including the done cycle)
//   done     out  one-cycle pulse when bcd_out/ovf hold fresh results
//   bcd_out  out  CH*DIGITS*4, channel i at [i*DIGITS*4 +: DIGITS*4], LS digit in low nibble
//   ovf      out  CH, bit i set when channel i >= 10^DIGITS (digits then saturate to 9s)
//
// Build option:
//   BCD_BLANK_EN  when defined, leading zero digits (never digit 0, never on
//                 overflow) are replaced by the blank code 4'hF at staging time.

module bin_to_bcd_seq #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2,
    parameter int CH     = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CH*WIDTH-1:0]     bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [CH*DIGITS*4-1:0]  bcd_out,
    output logic [CH-1:0]           ovf
);

    // Digits needed to represent any WIDTH-bit value, and scratch layout:
    // BCD digits in the upper NI*4 bits, binary operand in the low WIDTH bits.
    localparam int NI   = (WIDTH + 2) / 3;
    localparam int SW   = NI * 4 + WIDTH;
    localparam int MAXD = (NI > DIGITS) ? NI : DIGITS;
    localparam int DW   = DIGITS * 4;
    localparam int IW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int CW   = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_STORE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CH*WIDTH-1:0]    hold_q, hold_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]          scratch_q, scratch_d;
    logic [CH*DW-1:0]       stage_q, stage_d;
    logic [CH-1:0]          stage_ovf_q, stage_ovf_d;
    logic [CH*DW-1:0]       bcd_out_q, bcd_out_d;
    logic [CH-1:0]          ovf_q, ovf_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [WIDTH-1:0]       sel_bin;
    logic [SW-1:0]          adj;
    logic [MAXD*4-1:0]      ext;
    logic                   ovf_c;
    logic [DW-1:0]          staged;
`ifdef BCD_BLANK_EN
    logic                   seen_nz;
`endif

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        scratch_d   = scratch_q;
        stage_d     = stage_q;
        stage_ovf_d = stage_ovf_q;
        bcd_out_d   = bcd_out_q;
        ovf_d       = ovf_q;

        sel_bin = hold_q[int'(idx_q)*WIDTH +: WIDTH];

        // Add-3 correction on every BCD digit that would reach >= 10 after the shift.
        adj = scratch_q;
        for (int d = 0; d < NI; d++) begin
            if (scratch_q[WIDTH+d*4 +: 4] >= 4'd5)
                adj[WIDTH+d*4 +: 4] = scratch_q[WIDTH+d*4 +: 4] + 4'd3;
        end

        // Zero-extended digit view so DIGITS > NI simply reads leading zeros.
        ext = (MAXD*4)'(scratch_q[SW-1:WIDTH]);

        ovf_c = 1'b0;
        for (int d = DIGITS; d < MAXD; d++) begin
            if (ext[d*4 +: 4] != 4'd0)
                ovf_c = 1'b1;
        end

        for (int d = 0; d < DIGITS; d++)
            staged[d*4 +: 4] = ovf_c ? 4'h9 : ext[d*4 +: 4];

`ifdef BCD_BLANK_EN
        // Walk from the top digit down, blanking zeros until the first nonzero digit.
        seen_nz = 1'b0;
        if (!ovf_c) begin
            for (int d = DIGITS - 1; d >= 1; d--) begin
                if (staged[d*4 +: 4] != 4'd0)
                    seen_nz = 1'b1;
                else if (!seen_nz)
                    staged[d*4 +: 4] = 4'hF;
            end
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hold_d  = bin_in;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                scratch_d = SW'(sel_bin);
                cnt_d     = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                scratch_d = {adj[SW-2:0], 1'b0};
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = S_STORE;
            end
            S_STORE: begin
                stage_d[int'(idx_q)*DW +: DW] = staged;
                stage_ovf_d[idx_q]            = ovf_c;
                if (idx_q == IW'(CH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs update all at once, from the staging buffer including the
        // channel being written on this same edge.
        if (state_d == S_DONE) begin
            bcd_out_d = stage_d;
            ovf_d     = stage_ovf_d;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            scratch_q   <= '0;
            stage_q     <= '0;
            stage_ovf_q <= '0;
            bcd_out_q   <= '0;
            ovf_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            scratch_q   <= scratch_d;
            stage_q     <= stage_d;
            stage_ovf_q <= stage_ovf_d;
            bcd_out_q   <= bcd_out_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_out_q;
    assign ovf     = ovf_q;

endmodule
